// File: rtl/segway_pkg.sv
// Shared widths and saturation limits for the balance controller datapath.
// Used by the PID-term stage and the downstream duty stage.
package segway_pkg;

  localparam int PTCH_W = 16;
  localparam int ERR_W  = 10;
  localparam int DIFF_W = 7;

  localparam logic signed [ERR_W-1:0]  ERR_MAX  = 10'sh1FF;  //  511
  localparam logic signed [ERR_W-1:0]  ERR_MIN  = 10'sh200;  // -512
  localparam logic signed [DIFF_W-1:0] DIFF_MAX = 7'sh3F;    //  63
  localparam logic signed [DIFF_W-1:0] DIFF_MIN = 7'sh40;    // -64

endpackage

// File: rtl/ptch_d_queue.sv
// Circular history of saturated pitch errors for the derivative term.
// oldest is the entry written D_QUEUE_DEPTH pushes ago (read-before-write at ptr).
module ptch_d_queue
  import segway_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [ERR_W-1:0] din,
  output logic [ERR_W-1:0] oldest,
  output logic             full
);

  localparam int PTR_W = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(D_QUEUE_DEPTH + 1);

  logic [ERR_W-1:0] mem [D_QUEUE_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] fill_cnt;

  assign oldest = mem[ptr];
  assign full   = (fill_cnt == CNT_W'(D_QUEUE_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      fill_cnt <= '0;
      for (int i = 0; i < D_QUEUE_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      ptr      <= '0;
      fill_cnt <= '0;
      for (int i = 0; i < D_QUEUE_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PTR_W'(D_QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
      if (!full) fill_cnt <= fill_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ptch_pid_terms.sv
// Two-stage pipeline turning raw pitch samples into the saturated error,
// scaled integral and saturated derivative consumed by the duty stage.
module ptch_pid_terms
  import segway_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 10,
  parameter int INT_W         = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [PTCH_W-1:0] ptch,
  input  logic              pwr_up,
  input  logic              rider_off,
  output logic [ERR_W-1:0]  ptch_err_sat,
  output logic [ERR_W-1:0]  ptch_err_I,
  output logic [DIFF_W-1:0] ptch_D_diff_sat,
  output logic              terms_vld
);

  localparam logic signed [PTCH_W-1:0] P_MAX = PTCH_W'(ERR_MAX);
  localparam logic signed [PTCH_W-1:0] P_MIN = PTCH_W'(ERR_MIN);
  localparam logic signed [ERR_W:0]    D_MAX = (ERR_W + 1)'(DIFF_MAX);
  localparam logic signed [ERR_W:0]    D_MIN = (ERR_W + 1)'(DIFF_MIN);

  logic signed [ERR_W-1:0]  err_in;
  logic signed [ERR_W-1:0]  s1_err;
  logic                     s1_vld;
  logic signed [INT_W-1:0]  integ;
  logic signed [INT_W-1:0]  err_ext;
  logic signed [INT_W-1:0]  sum;
  logic signed [INT_W-1:0]  integ_upd;
  logic                     ovf;
  logic [ERR_W-1:0]         oldest;
  logic                     full;
  logic signed [ERR_W:0]    diff;
  logic [DIFF_W-1:0]        d_sat;
  logic                     upd;

  always_comb begin
    err_in = ptch[ERR_W-1:0];
    if ($signed(ptch) > P_MAX)      err_in = ERR_MAX;
    else if ($signed(ptch) < P_MIN) err_in = ERR_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err <= '0;
      s1_vld <= 1'b0;
    end else if (!pwr_up) begin
      s1_err <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= vld;
      if (vld) s1_err <= err_in;
    end
  end

  assign upd     = s1_vld & pwr_up;
  assign err_ext = INT_W'(s1_err);
  assign sum     = integ + err_ext;
  // Overflow: like-signed operands whose sum flips sign; the accumulator then holds.
  assign ovf       = (integ[INT_W-1] == s1_err[ERR_W-1]) && (sum[INT_W-1] != integ[INT_W-1]);
  assign integ_upd = ovf ? integ : sum;

  assign diff = {s1_err[ERR_W-1], s1_err} - {oldest[ERR_W-1], oldest};

  always_comb begin
    d_sat = diff[DIFF_W-1:0];
    if (diff > D_MAX)      d_sat = DIFF_MAX;
    else if (diff < D_MIN) d_sat = DIFF_MIN;
  end

  ptch_d_queue #(
    .D_QUEUE_DEPTH(D_QUEUE_DEPTH)
  ) u_d_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!pwr_up),
    .push  (upd),
    .din   (s1_err),
    .oldest(oldest),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ           <= '0;
      ptch_err_sat    <= '0;
      ptch_err_I      <= '0;
      ptch_D_diff_sat <= '0;
      terms_vld       <= 1'b0;
    end else begin
      terms_vld <= upd;
      if (!pwr_up || rider_off) integ <= '0;
      else if (upd)             integ <= integ_upd;
      if (upd) begin
        ptch_err_sat    <= s1_err;
        ptch_err_I      <= rider_off ? '0 : integ_upd[INT_W-1 -: ERR_W];
        ptch_D_diff_sat <= full ? d_sat : '0;
      end
    end
  end

endmodule

// File: tb/tb_ptch_pid_terms.sv
// Self-checking bench for ptch_pid_terms: constant table plus a scoreboard
// fed by a behavioural model at stimulus time and drained on terms_vld.
module tb_ptch_pid_terms;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] ptch = '0;
  logic        pwr_up = 1'b0;
  logic        rider_off = 1'b0;
  logic [9:0]  ptch_err_sat;
  logic [9:0]  ptch_err_I;
  logic [6:0]  ptch_D_diff_sat;
  logic        terms_vld;

  always #5 clk = ~clk;

  ptch_pid_terms #(
    .D_QUEUE_DEPTH(10),
    .INT_W        (18)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vld            (vld),
    .ptch           (ptch),
    .pwr_up         (pwr_up),
    .rider_off      (rider_off),
    .ptch_err_sat   (ptch_err_sat),
    .ptch_err_I     (ptch_err_I),
    .ptch_D_diff_sat(ptch_D_diff_sat),
    .terms_vld      (terms_vld)
  );

  typedef struct {
    int sat;
    int i_t;
    int d;
    int due;
  } exp_t;

  typedef struct {
    int ptch;
    int sat;
    int i_t;
    int d;
  } vec_t;

  exp_t sb[$];
  int   hist[$];
  int   m_integ = 0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clamp(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated when the sample is driven.
  task automatic model_push(int p, bit rider);
    int err, s, i_t, d;
    err = clamp(p, -512, 511);
    s   = m_integ + err;
    if (s <= 131071 && s >= -131072) m_integ = s;
    if (rider) m_integ = 0;
    i_t = rider ? 0 : (m_integ >>> 8);
    d   = (hist.size() >= 10) ? clamp(err - hist[0], -64, 63) : 0;
    hist.push_back(err);
    if (hist.size() > 10) void'(hist.pop_front());
    sb.push_back('{err, i_t, d, cyc + 2});
  endtask

  task automatic send(int p, bit rider);
    vld  = 1'b1;
    ptch = 16'(p);
    model_push(p, rider);
    tick();
    vld = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic power_cycle();
    pwr_up = 1'b0;
    m_integ = 0;
    hist.delete();
    tick();
    tick();
    pwr_up = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_terms_vld: got none by cycle %0d, expected at cycle %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (terms_vld === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_terms_vld: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency_cycle", cyc, e.due);
        chk("ptch_err_sat", $signed(ptch_err_sat), e.sat);
        chk("ptch_err_I", $signed(ptch_err_I), e.i_t);
        chk("ptch_D_diff_sat", $signed(ptch_D_diff_sat), e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{1000, 511, 1, 0};
    tbl[1] = '{-2000, -512, -1, 0};
    tbl[2] = '{-37, -37, -1, 0};
    tbl[3] = '{0, 0, -1, 0};

    repeat (3) tick();
    chk("reset_sat", $signed(ptch_err_sat), 0);
    chk("reset_I", $signed(ptch_err_I), 0);
    chk("reset_D", $signed(ptch_D_diff_sat), 0);
    chk("reset_terms_vld", int'(terms_vld), 0);
    rst_n  = 1'b1;
    pwr_up = 1'b1;
    tick();

    // Saturation, back-to-back samples, constant expectations.
    for (int i = 0; i < 4; i++) begin
      vld  = 1'b1;
      ptch = 16'(tbl[i].ptch);
      sb.push_back('{tbl[i].sat, tbl[i].i_t, tbl[i].d, cyc + 2});
      tick();
    end
    vld = 1'b0;
    drain();
    power_cycle();

    // Integration.
    for (int i = 0; i < 4; i++) send(256, 1'b0);
    drain();
    chk("integ_I_after_4", $signed(ptch_err_I), 4);

    // rider_off coincident with the stage-2 update.
    send(100, 1'b1);
    rider_off = 1'b1;
    tick();
    rider_off = 1'b0;
    drain();
    chk("rider_I_cleared", $signed(ptch_err_I), 0);
    chk("rider_sat_updated", $signed(ptch_err_sat), 100);
    power_cycle();

    // Integrator overflow hold.
    for (int i = 0; i < 257; i++) send(511, 1'b0);
    drain();
    chk("overflow_hold_I", $signed(ptch_err_I), 511);
    power_cycle();

    // Derivative fill phase and saturation.
    for (int i = 0; i < 10; i++) send(0, 1'b0);
    send(40, 1'b0);
    send(200, 1'b0);
    send(-300, 1'b0);
    drain();
    chk("deriv_neg_sat", $signed(ptch_D_diff_sat), -64);

    // Samples while powered down are dropped; history restarts on re-enable.
    pwr_up = 1'b0;
    m_integ = 0;
    hist.delete();
    tick();
    vld  = 1'b1;
    ptch = 16'd123;
    repeat (3) tick();
    vld = 1'b0;
    repeat (3) tick();
    pwr_up = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) send(int'($urandom_range(1200, 0)) - 600, 1'b0);
    drain();

    // Reset with a sample in stage 1.
    send(77, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    m_integ = 0;
    hist.delete();
    @(negedge clk);
    chk("midrst_sat", $signed(ptch_err_sat), 0);
    chk("midrst_I", $signed(ptch_err_I), 0);
    chk("midrst_D", $signed(ptch_D_diff_sat), 0);
    chk("midrst_terms_vld", int'(terms_vld), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(5, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
